multicycle_ctrl: RTL

Main control FSM for the multicycle MIPS datapath. It decodes `op`/`funct` from the instruction register and drives every datapath enable and select, including `IRWrite`, which loads the instruction register. It also runs a req/ready handshake with the unified instruction/data memory, so fetches and data accesses may take any number of wait cycles. The ALU decoder, which maps ALUOp/funct to the ALU control code, is folded into this block.

---
 rtl/multicycle_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM and ALU decoder for the multicycle MIPS datapath with req/ready memory
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCEn,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FN = 2'b10;
  typedef enum logic [3:0] {
    RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;
  state_t state, next;
  logic pc_write, branch;
  logic [1:0] alu_op;
  logic [2:0] funct_ctl;
  // State register; reset_n low forces RESET immediately, aborting any pending access
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RESET;
    else state <= next;
  // Next-state and per-state datapath controls; everything not named for a state stays 0
  always_comb begin
    next = state;
    mem_req = 1'b0;
    MemWrite = 1'b0;
    IorD = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    PCSrc = 2'b00;
    pc_write = 1'b0;
    branch = 1'b0;
    alu_op = ALU_ADD;
    illegal_instr = 1'b0;
    case (state)
      RESET: next = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        pc_write = mem_ready;
        next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R: next = EXECUTE;
          OP_BEQ: next = BRANCH;
          OP_ADDI: next = ADDIEXEC;
          OP_J: next = JUMP;
          default: begin
            next = FETCH;
            illegal_instr = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        next = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD = 1'b1;
        next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        next = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        MemWrite = 1'b1;
        IorD = 1'b1;
        next = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op = ALU_FN;
        next = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op = ALU_SUB;
        branch = 1'b1;
        PCSrc = 2'b01;
        next = FETCH;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        next = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        next = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        PCSrc = 2'b10;
        next = FETCH;
      end
      default: next = RESET;
    endcase
  end
  // ALU decoder; unknown R-type functs fall back to add so the instruction still completes
  always_comb begin
    funct_ctl = funct == 6'b100010 ? 3'b110 :
                funct == 6'b100100 ? 3'b000 :
                funct == 6'b100101 ? 3'b001 :
                funct == 6'b101010 ? 3'b111 : 3'b010;
    ALUControl = state == RESET ? 3'b000 :
                 alu_op == ALU_SUB ? 3'b110 :
                 alu_op == ALU_FN ? funct_ctl : 3'b010;
  end
  assign PCEn = pc_write | (branch & zero);
endmodule
